// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (D); grants are combinational, responses arrive MEM_LAT cycles after the grant.
// One access is in flight at a time; requesters hold req until gnt. Define MEM_ARB_RR_EN for round-robin on contention (default: data wins).
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       kill_q, kill_d;
    logic       own_d_q, own_d_d;
    logic       store_q, store_d;
    logic       resp, slot, pref_d, win_d, gnt_any;

`ifdef MEM_ARB_RR_EN
    // rr_q = 1 means the data port is preferred on the next contention
    logic rr_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b0;
        end else if (gnt_any) begin
            rr_q <= if_gnt;
        end
    end
    assign pref_d = rr_q;
`else
    assign pref_d = 1'b1;
`endif

    always_comb begin
        resp    = (state_q == S_WAIT) && (cnt_q == 4'd0);
        slot    = rst && ((state_q == S_IDLE) || resp);
        win_d   = d_req && (!if_req || pref_d);
        d_gnt   = slot && win_d;
        if_gnt  = slot && if_req && !win_d;
        gnt_any = d_gnt || if_gnt;

        mem_en     = gnt_any;
        mem_we     = d_gnt && d_we;
        mem_funct3 = d_gnt ? d_funct3 : (if_gnt ? 3'b010 : 3'b000);
        mem_addr   = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
        mem_wdata  = d_gnt ? d_wdata : '0;

        // a kill raised in the response cycle itself still suppresses that response
        if_rvalid = resp && !own_d_q && !(kill_q || if_kill);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rvalid  = resp && own_d_q;
        d_rdata   = (d_rvalid && !store_q) ? mem_rdata : '0;
        busy      = (state_q == S_WAIT);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        own_d_d = own_d_q;
        store_d = store_q;
        if (gnt_any) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
            kill_d  = 1'b0;
            own_d_d = d_gnt;
            store_d = d_gnt && d_we;
        end else if (resp) begin
            state_d = S_IDLE;
            kill_d  = 1'b0;
        end else if (state_q == S_WAIT) begin
            cnt_d  = cnt_q - 4'd1;
            kill_d = kill_q || (if_kill && !own_d_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            kill_q  <= 1'b0;
            own_d_q <= 1'b0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            own_d_q <= own_d_d;
            store_q <= store_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checks every output each cycle, plus literal pins per cycle.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0;
    logic        if_req, if_kill, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  d_funct3;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;
    int          pin_id [2];
    logic [31:0] pin_val [2];
    string nm [1:12] = '{"if_gnt", "d_gnt", "mem_en", "mem_we", "mem_funct3", "mem_addr",
                         "mem_wdata", "if_rvalid", "if_rdata", "d_rvalid", "d_rdata", "busy"};

    function automatic logic [31:0] out_val(int id);
        case (id)
            1:  return {31'b0, if_gnt};
            2:  return {31'b0, d_gnt};
            3:  return {31'b0, mem_en};
            4:  return {31'b0, mem_we};
            5:  return {29'b0, mem_funct3};
            6:  return mem_addr;
            7:  return mem_wdata;
            8:  return {31'b0, if_rvalid};
            9:  return if_rdata;
            10: return {31'b0, d_rvalid};
            11: return d_rdata;
            default: return {31'b0, busy};
        endcase
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding access with an absolute response cycle.
    bit m_busy, m_own_d, m_store, m_killed, m_pref_d;
    int m_resp_cyc;

    always @(negedge clk) begin
        logic        resp, slot, wd, edg, eig, g, eirv, edrv;
        logic [31:0] e [1:12];
        bit          c [1:12];
        if (!rst) begin
            m_busy = 0; m_killed = 0; m_pref_d = 0; m_own_d = 0; m_store = 0;
            for (int i = 1; i <= 12; i++) cmp({"rst_", nm[i]}, out_val(i), 32'h0);
        end else begin
            resp = m_busy && (cyc == m_resp_cyc);
            slot = !m_busy || resp;
            wd   = d_req && (!if_req || (RR ? m_pref_d : 1'b1));
            edg  = slot && wd;
            eig  = slot && if_req && !wd;
            g    = edg || eig;
            eirv = resp && !m_own_d && !(m_killed || if_kill);
            edrv = resp && m_own_d;
            e[1] = {31'b0, eig};
            e[2] = {31'b0, edg};
            e[3] = {31'b0, g};
            e[4] = {31'b0, edg && d_we};
            e[5] = edg ? {29'b0, d_funct3} : 32'd2;
            e[6] = edg ? d_addr : if_addr;
            e[7] = edg ? d_wdata : 32'h0;
            e[8] = {31'b0, eirv};
            e[9] = eirv ? mem_rdata : 32'h0;
            e[10] = {31'b0, edrv};
            e[11] = (edrv && !m_store) ? mem_rdata : 32'h0;
            e[12] = {31'b0, m_busy};
            for (int i = 1; i <= 12; i++) c[i] = (i >= 4 && i <= 7) ? g : 1'b1;
            for (int i = 1; i <= 12; i++) if (c[i]) cmp(nm[i], out_val(i), e[i]);
            if (m_busy && !m_own_d && if_kill) m_killed = 1;
            if (g) begin
                m_busy = 1; m_own_d = edg; m_store = edg && d_we; m_killed = 0;
                m_resp_cyc = cyc + LAT; m_pref_d = eig;
            end else if (resp) begin
                m_busy = 0;
            end
        end
        for (int p = 0; p < 2; p++)
            if (pin_id[p] != 0) cmp({"pin_", nm[pin_id[p]]}, out_val(pin_id[p]), pin_val[p]);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        pin_id[0] = 0;
        pin_id[1] = 0;
    endtask

    task automatic pin(int id, logic [31:0] v);
        if (pin_id[0] == 0) begin pin_id[0] = id; pin_val[0] = v; end
        else begin pin_id[1] = id; pin_val[1] = v; end
    endtask

    task automatic idle_in();
        if_req = 0; if_kill = 0; if_addr = 0; d_req = 0; d_we = 0; d_funct3 = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0;
    endtask

    initial begin
        pin_id[0] = 0; pin_id[1] = 0;
        idle_in();
        pin(12, 0); pin(3, 0); nxt(); nxt();
        rst = 1; nxt();

        // lone fetch
        if_req = 1; if_addr = 32'h100; pin(1, 1); pin(6, 32'h100); nxt();
        if_req = 0; pin(12, 1); nxt();
        mem_rdata = 32'h00500093; pin(8, 1); pin(9, 32'h00500093); nxt();
        mem_rdata = 0; pin(12, 0); nxt();

        // contention
`ifdef MEM_ARB_RR_EN
        rst = 0; nxt(); rst = 1; nxt();
        if_req = 1; if_addr = 32'h200; d_req = 1; d_funct3 = 3'b100; d_addr = 32'h2000;
        for (int k = 0; k < 8; k++) begin
            mem_rdata = 32'h1000 + k;
            if (k == 0 || k == 4) begin pin(1, 1); pin(2, 0); end
            if (k == 2 || k == 6) begin pin(2, 1); pin(1, 0); end
            nxt();
        end
        idle_in(); nxt();
`else
        if_req = 1; if_addr = 32'h200; d_req = 1; d_funct3 = 3'b100; d_addr = 32'h2000;
        pin(2, 1); pin(1, 0); nxt();
        d_req = 0; nxt();
        mem_rdata = 32'h11223344; pin(1, 1); pin(10, 1); nxt();
        if_req = 0; mem_rdata = 0; nxt();
        mem_rdata = 32'h55667788; pin(8, 1); pin(9, 32'h55667788); nxt();
`endif
        idle_in(); nxt(); nxt();

        // store
        d_req = 1; d_we = 1; d_funct3 = 3'b010; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        pin(4, 1); pin(7, 32'hDEADBEEF); nxt();
        d_req = 0; d_we = 0; nxt();
        mem_rdata = 32'hFFFFFFFF; pin(10, 1); pin(11, 0); nxt();
        idle_in(); nxt();

        // kill mid-wait, then a normal fetch
        if_req = 1; if_addr = 32'h300; pin(1, 1); nxt();
        if_req = 0; if_kill = 1; nxt();
        if_kill = 0; mem_rdata = 32'hAAAA5555; pin(8, 0); pin(12, 1); nxt();
        mem_rdata = 0; if_req = 1; if_addr = 32'h304; pin(12, 0); pin(1, 1); nxt();
        if_req = 0; nxt();
        mem_rdata = 32'h00000013; pin(8, 1); pin(9, 32'h13); nxt();
        idle_in(); nxt();

        // back-to-back fetches, kill only in the response cycle of the first
        if_req = 1; if_addr = 32'h400; nxt();
        if_addr = 32'h404; nxt();
        if_kill = 1; mem_rdata = 32'hBAD0BAD0; pin(8, 0); pin(1, 1); nxt();
        if_kill = 0; if_req = 0; mem_rdata = 0; nxt();
        mem_rdata = 32'h12345678; pin(8, 1); pin(9, 32'h12345678); nxt();
        idle_in(); nxt();

        // kill during a data load is ignored
        d_req = 1; d_funct3 = 3'b000; d_addr = 32'h80; pin(2, 1); nxt();
        d_req = 0; if_kill = 1; nxt();
        mem_rdata = 32'h0BADF00D; pin(10, 1); pin(11, 32'h0BADF00D); nxt();
        idle_in(); nxt();

        // kill in idle and in the grant cycle has no effect
        if_kill = 1; nxt();
        if_req = 1; if_addr = 32'h600; pin(1, 1); nxt();
        if_kill = 0; if_req = 0; nxt();
        mem_rdata = 32'h00C0FFEE; pin(8, 1); pin(9, 32'h00C0FFEE); nxt();
        idle_in(); nxt();

        // async reset during wait
        if_req = 1; if_addr = 32'h500; pin(1, 1); nxt();
        if_req = 0; rst = 0; pin(12, 0); pin(3, 0); nxt();
        mem_rdata = 32'hCAFEF00D; pin(8, 0); nxt();
        rst = 1; if_req = 1; if_addr = 32'h504; pin(1, 1); pin(8, 0); nxt();
        if_req = 0; mem_rdata = 32'hCAFEF00D; pin(8, 0); nxt();
        mem_rdata = 32'h77; pin(8, 1); pin(9, 32'h77); nxt();
        idle_in(); nxt(); nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
